// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: one shared ALU, ready/valid memory port and an internal
// memory-mapped I/O window (PortOut at IO_BASE, PortIn at IO_BASE+4).
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0] IO_BASE       = 32'hFFFF_0000,
  parameter int unsigned PORT_IN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_rdata,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic [31:0]              PortOut,
  output logic [31:0]              PCOut,
  output logic [31:0]              ALUResultOut,
  output logic                     halted
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;
  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluNor, AluSlt, AluSll, AluSrl, AluLui
  } alu_op_e;

  state_e      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_out_q, mdr_q, port_out_q;
  logic        mem_req_q;
  logic [31:0] rf_q [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, wb_addr;
  logic [15:0] imm;
  logic [31:0] sext_imm, imm_val, rf_rs, rf_rt, wb_data;
  logic        legal, use_imm, wb_rd, is_branch, is_jr, is_jump, is_jal, is_lw, is_sw, taken;
  alu_op_e     alu_op_dec, alu_op;
  logic [31:0] alu_a, alu_b, alu_res;

  function automatic logic is_io(input logic [31:0] addr);
    return (addr == IO_BASE) || (addr == IO_BASE + 32'd4);
  endfunction

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign rf_rs    = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rf_rt    = (rt == 5'd0) ? 32'd0 : rf_q[rt];
  assign taken    = opcode[0] ? (a_q != b_q) : (a_q == b_q);
  assign wb_addr  = wb_rd ? rd : rt;
  assign wb_data  = is_lw ? mdr_q : alu_out_q;

  always_comb begin
    legal      = 1'b1;
    alu_op_dec = AluAdd;
    use_imm    = 1'b0;
    imm_val    = sext_imm;
    wb_rd      = 1'b0;
    is_branch  = 1'b0;
    is_jr      = 1'b0;
    is_jump    = 1'b0;
    is_jal     = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    case (opcode)
      6'h00: begin
        wb_rd = 1'b1;
        case (funct)
          6'h20:   alu_op_dec = AluAdd;
          6'h22:   alu_op_dec = AluSub;
          6'h24:   alu_op_dec = AluAnd;
          6'h25:   alu_op_dec = AluOr;
          6'h27:   alu_op_dec = AluNor;
          6'h2a:   alu_op_dec = AluSlt;
          6'h00:   alu_op_dec = AluSll;
          6'h02:   alu_op_dec = AluSrl;
          6'h08:   is_jr = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      6'h08: use_imm = 1'b1;
      6'h0c: begin use_imm = 1'b1; imm_val = {16'd0, imm}; alu_op_dec = AluAnd; end
      6'h0d: begin use_imm = 1'b1; imm_val = {16'd0, imm}; alu_op_dec = AluOr;  end
      6'h0f: begin use_imm = 1'b1; alu_op_dec = AluLui; end
      6'h0a: begin use_imm = 1'b1; alu_op_dec = AluSlt; end
      6'h23: begin use_imm = 1'b1; is_lw = 1'b1; end
      6'h2b: begin use_imm = 1'b1; is_sw = 1'b1; end
      6'h04, 6'h05: is_branch = 1'b1;
      6'h02: is_jump = 1'b1;
      6'h03: begin is_jump = 1'b1; is_jal = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  // The single ALU: PC+4 in FETCH, branch target in DECODE, the instruction's op otherwise.
  always_comb begin
    alu_a  = a_q;
    alu_b  = use_imm ? imm_val : b_q;
    alu_op = alu_op_dec;
    case (state_q)
      StFetch:  begin alu_a = pc_q; alu_b = 32'd4; alu_op = AluAdd; end
      StDecode: begin alu_a = pc_q; alu_b = {sext_imm[29:0], 2'b00}; alu_op = AluAdd; end
      default:  ;
    endcase
    case (alu_op)
      AluSub:  alu_res = alu_a - alu_b;
      AluAnd:  alu_res = alu_a & alu_b;
      AluOr:   alu_res = alu_a | alu_b;
      AluNor:  alu_res = ~(alu_a | alu_b);
      AluSlt:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      AluSll:  alu_res = alu_b << shamt;
      AluSrl:  alu_res = alu_b >> shamt;
      AluLui:  alu_res = {imm, 16'd0};
      default: alu_res = alu_a + alu_b;
    endcase
  end

  // mem_req is registered: FETCH right after reset spends one cycle raising it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      ir_q       <= 32'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      alu_out_q  <= 32'd0;
      mdr_q      <= 32'd0;
      port_out_q <= 32'd0;
      mem_req_q  <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (mem_ready) begin
            ir_q      <= mem_rdata;
            pc_q      <= alu_res;
            mem_req_q <= 1'b0;
            state_q   <= StDecode;
          end
        end
        StDecode: begin
          a_q       <= rf_rs;
          b_q       <= rf_rt;
          alu_out_q <= alu_res;
          if (!legal) begin
            state_q <= StTrap;
          end else if (is_jump) begin
            pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
            if (is_jal) rf_q[31] <= pc_q;
            mem_req_q <= 1'b1;
            state_q   <= StFetch;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          if (is_branch || is_jr) begin
            if (is_jr) pc_q <= a_q;
            else if (taken) pc_q <= alu_out_q;
            mem_req_q <= 1'b1;
            state_q   <= StFetch;
          end else begin
            alu_out_q <= alu_res;
            if (!(is_lw || is_sw)) begin
              state_q <= StWb;
            end else if (alu_res[1:0] != 2'b00) begin
              state_q <= StTrap;
            end else begin
              mem_req_q <= !is_io(alu_res);
              state_q   <= StMem;
            end
          end
        end
        StMem: begin
          if (is_io(alu_out_q)) begin
            if (alu_out_q == IO_BASE) begin
              mdr_q <= 32'd0;
              if (is_sw) port_out_q <= b_q;
            end else begin
              mdr_q <= 32'(PortIn);
            end
            mem_req_q <= is_sw;
            state_q   <= is_lw ? StWb : StFetch;
          end else if (mem_ready) begin
            if (is_lw) mdr_q <= mem_rdata;
            mem_req_q <= is_sw;
            state_q   <= is_lw ? StWb : StFetch;
          end
        end
        StWb: begin
          if (wb_addr != 5'd0) rf_q[wb_addr] <= wb_data;
          mem_req_q <= 1'b1;
          state_q   <= StFetch;
        end
        StTrap: ;
        default: state_q <= StTrap;
      endcase
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = (state_q == StMem) && is_sw;
  assign mem_addr     = (state_q == StMem) ? alu_out_q : pc_q;
  assign mem_wdata    = b_q;
  assign PortOut      = port_out_q;
  assign PCOut        = pc_q;
  assign ALUResultOut = alu_out_q;
  assign halted       = (state_q == StTrap);

endmodule
